// File: rtl/blit_loop_seq_pkg.sv
// blit_pkg: shared types and constants for the blit loop sequencer (BLIT_LOOP_STOP_EN adds STOPPED use)
package blit_pkg;
  localparam int CW_DEF = 16;
  localparam int IN_FIELD = 0;
  localparam int OUT_FIELD = 1;
  typedef enum logic [2:0] {IDLE, INNER, ROWEND, FIN, STOPPED} state_t;
endpackage

// File: rtl/blit_loop_seq_if.sv
// blit_loop_seq_if: GPU register and datapath handshake bundle; stop/resume exist only with BLIT_LOOP_STOP_EN
interface blit_loop_seq_if import blit_pkg::*; #(parameter int CW = CW_DEF);
  logic [2*CW-1:0] gpu_din;
  logic countld, go, step_ack, inner_req, outer_step, busy, done, outer0;
  logic [CW-1:0] ocount, icount;
`ifdef BLIT_LOOP_STOP_EN
  logic stop, resume;
  modport master(output gpu_din, countld, go, step_ack, stop, resume,
                 input inner_req, outer_step, busy, done, ocount, icount, outer0);
  modport slave(input gpu_din, countld, go, step_ack, stop, resume,
                output inner_req, outer_step, busy, done, ocount, icount, outer0);
`else
  modport master(output gpu_din, countld, go, step_ack,
                 input inner_req, outer_step, busy, done, ocount, icount, outer0);
  modport slave(input gpu_din, countld, go, step_ack,
                output inner_req, outer_step, busy, done, ocount, icount, outer0);
`endif
endinterface

// File: rtl/blit_loop_seq_dcount.sv
// blit_dcount: loadable down-counter that saturates at zero, with zero flag
module blit_dcount #(parameter int CW = 16) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] data,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);
  assign zero = count == '0;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= data;
    else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/blit_loop_seq.sv
// blit_loop_seq: sequences blitter inner (pixel) and outer (row) loops; BLIT_LOOP_STOP_EN adds collision stop/resume
module blit_loop_seq import blit_pkg::*; #(parameter int CW = CW_DEF) (
  input logic clk,
  input logic reset,
  blit_loop_seq_if.slave bus
);
  state_t state, nxt;
  logic [CW-1:0] iwidth, din_i, din_o;
  logic ld, stall, izero, ozero, done_r;
  assign din_i = bus.gpu_din[IN_FIELD*CW +: CW];
  assign din_o = bus.gpu_din[OUT_FIELD*CW +: CW];
  assign ld = state == IDLE && bus.countld;
`ifdef BLIT_LOOP_STOP_EN
  state_t saved;
  assign stall = bus.stop && (state == INNER || state == ROWEND);
  always_ff @(posedge clk)
    if (reset) saved <= IDLE;
    else if (stall) saved <= state;
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (bus.go) nxt = (ld ? din_o == '0 : ozero) ? FIN : (ld ? din_i == '0 : izero) ? ROWEND : INNER;
      INNER:  if (bus.step_ack && bus.icount == CW'(1)) nxt = ROWEND;
      ROWEND: nxt = bus.ocount == CW'(1) ? FIN : iwidth == '0 ? ROWEND : INNER;
      FIN:    nxt = IDLE;
`ifdef BLIT_LOOP_STOP_EN
      STOPPED: if (bus.resume) nxt = saved;
`endif
      default: nxt = IDLE;
    endcase
    if (stall) nxt = STOPPED;
  end
  // done is registered off FIN so it lands in the cycle busy falls
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      iwidth <= '0;
      done_r <= 1'b0;
    end else begin
      state <= nxt;
      done_r <= state == FIN;
      if (ld) iwidth <= din_i;
    end
  blit_dcount #(.CW(CW)) u_icnt (
    .clk(clk), .reset(reset),
    .load(ld || (state == ROWEND && !stall)),
    .data(ld ? din_i : iwidth),
    .dec(state == INNER && bus.step_ack && !stall),
    .count(bus.icount), .zero(izero)
  );
  blit_dcount #(.CW(CW)) u_ocnt (
    .clk(clk), .reset(reset),
    .load(ld), .data(din_o),
    .dec(state == ROWEND && !stall),
    .count(bus.ocount), .zero(ozero)
  );
  assign bus.inner_req = state == INNER;
  assign bus.outer_step = state == ROWEND && !stall;
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.outer0 = ozero;
endmodule

// File: tb/tb_blit_loop_seq.sv
// tb_blit_loop_seq: scoreboard bench for blit_loop_seq; row/done events are queued at launch and checked as they appear
module tb_blit_loop_seq;
  localparam int CW = 16;
  typedef struct { int kind; int oc; int acks; } ev_t;
  logic clk = 0, reset = 1, stp;
  int total = 0, bad = 0;
  int n_hs = 0, n_os = 0, n_done = 0, n_req = 0, n_busy = 0, row_acks = 0;
  ev_t q[$];
  ev_t e;
  blit_loop_seq_if #(.CW(CW)) bus();
  blit_loop_seq #(.CW(CW)) dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef BLIT_LOOP_STOP_EN
  assign stp = bus.stop;
`else
  assign stp = 1'b0;
`endif
  always @(negedge clk) begin
    if (reset) row_acks = 0;
    else begin
      if (bus.inner_req && bus.step_ack && !stp) begin row_acks++; n_hs++; end
      if (bus.inner_req) n_req++;
      if (bus.busy) n_busy++;
      if (bus.outer_step) begin
        n_os++; total++;
        if (q.size() == 0 || q[0].kind != 0) begin
          bad++; $display("FAIL outer_step: unexpected pulse, ocount=%0d", bus.ocount);
        end else begin
          e = q.pop_front();
          if (int'(bus.ocount) !== e.oc || row_acks !== e.acks) begin
            bad++; $display("FAIL row: ocount=%0d acks=%0d want ocount=%0d acks=%0d", bus.ocount, row_acks, e.oc, e.acks);
          end
        end
        row_acks = 0;
      end
      if (bus.done) begin
        n_done++; total++;
        if (q.size() == 0 || q[0].kind != 1) begin
          bad++; $display("FAIL done: unexpected pulse, %0d events still pending", q.size());
        end else e = q.pop_front();
      end
    end
  end
  task automatic push_run(input int o, input int i);
    for (int r = o; r >= 1; r--) q.push_back('{0, r, i});
    q.push_back('{1, 0, 0});
  endtask
  task automatic start(input logic [2*CW-1:0] d, input bit same);
    bus.gpu_din = d; bus.countld = 1;
    if (!same) begin @(posedge clk); #1; bus.countld = 0; end
    bus.go = 1; @(posedge clk); #1;
    bus.go = 0; bus.countld = 0;
  endtask
  task automatic wait_done(input int budget, output int lat);
    int d0 = n_done;
    lat = 0;
    while (n_done == d0 && lat < budget) begin @(negedge clk); #1; lat++; end
    total++;
    if (n_done == d0) begin bad++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    bus.gpu_din = '0; bus.countld = 0; bus.go = 0; bus.step_ack = 0;
`ifdef BLIT_LOOP_STOP_EN
    bus.stop = 0; bus.resume = 0;
`endif
    repeat (3) @(posedge clk); #1;
    total++;
    if ({bus.inner_req, bus.outer_step, bus.busy, bus.done, bus.outer0} !== 5'b00001) begin
      bad++; $display("FAIL reset_flags: got %b want 00001", {bus.inner_req, bus.outer_step, bus.busy, bus.done, bus.outer0});
    end
    total++;
    if (bus.ocount !== 16'd0 || bus.icount !== 16'd0) begin
      bad++; $display("FAIL reset_counts: ocount=%0d icount=%0d want 0 0", bus.ocount, bus.icount);
    end
    reset = 0; @(posedge clk); #1;
  endtask
  task automatic test_basic;
    int h0 = n_hs, o0 = n_os, d0 = n_done, lat;
    push_run(3, 4);
    bus.step_ack = 1;
    start(32'h0003_0004, 0);
    wait_done(200, lat);
    repeat (3) @(posedge clk); #1;
    bus.step_ack = 0;
    total++; if (n_hs - h0 !== 12) begin bad++; $display("FAIL basic_steps: got %0d want 12", n_hs - h0); end
    total++; if (n_os - o0 !== 3) begin bad++; $display("FAIL basic_rows: got %0d want 3", n_os - o0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL basic_done: got %0d want 1", n_done - d0); end
    total++; if (bus.ocount !== 16'd0 || bus.outer0 !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL basic_end: ocount=%0d outer0=%b busy=%b want 0 1 0", bus.ocount, bus.outer0, bus.busy);
    end
  endtask
  task automatic test_ack_toggle;
    int h0 = n_hs, o0 = n_os, d0 = n_done;
    logic [CW-1:0] hold = '0;
    bit chk = 0;
    push_run(2, 3);
    bus.step_ack = 0;
    start(32'h0002_0003, 0);
    for (int k = 0; k < 100 && n_done == d0; k++) begin
      bus.step_ack = (k % 2 == 1);
      @(negedge clk); #1;
      if (chk) begin
        total++;
        if (bus.icount !== hold) begin bad++; $display("FAIL toggle_hold: icount=%0d want %0d", bus.icount, hold); end
        chk = 0;
      end
      if (bus.inner_req && !bus.step_ack) begin hold = bus.icount; chk = 1; end
      @(posedge clk); #1;
    end
    bus.step_ack = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (n_hs - h0 !== 6) begin bad++; $display("FAIL toggle_steps: got %0d want 6", n_hs - h0); end
    total++; if (n_os - o0 !== 2) begin bad++; $display("FAIL toggle_rows: got %0d want 2", n_os - o0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL toggle_done: got %0d want 1", n_done - d0); end
  endtask
  task automatic test_zero_rows;
    int r0 = n_req, b0 = n_busy, lat;
    push_run(0, 5);
    bus.step_ack = 1;
    start(32'h0000_0005, 1);
    wait_done(20, lat);
    bus.step_ack = 0;
    total++; if (lat !== 2) begin bad++; $display("FAIL zrows_latency: got %0d want 2", lat); end
    total++; if (n_busy - b0 !== 1) begin bad++; $display("FAIL zrows_busy: got %0d want 1", n_busy - b0); end
    total++; if (n_req - r0 !== 0) begin bad++; $display("FAIL zrows_req: got %0d want 0", n_req - r0); end
  endtask
  task automatic test_zero_width;
    int r0 = n_req, o0 = n_os, lat;
    push_run(3, 0);
    start(32'h0003_0000, 1);
    wait_done(30, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL zwidth_latency: got %0d want 5", lat); end
    total++; if (n_os - o0 !== 3) begin bad++; $display("FAIL zwidth_rows: got %0d want 3", n_os - o0); end
    total++; if (n_req - r0 !== 0) begin bad++; $display("FAIL zwidth_req: got %0d want 0", n_req - r0); end
  endtask
  task automatic test_busy_ignore;
    int h0 = n_hs, o0 = n_os, d0 = n_done, lat;
    push_run(2, 3);
    bus.step_ack = 1;
    start(32'h0002_0003, 0);
    @(posedge clk); #1;
    bus.gpu_din = 32'h0001_0001; bus.countld = 1; bus.go = 1;
    @(posedge clk); #1;
    bus.countld = 0; bus.go = 0;
    wait_done(100, lat);
    repeat (4) @(posedge clk); #1;
    bus.step_ack = 0;
    total++; if (n_hs - h0 !== 6) begin bad++; $display("FAIL ignore_steps: got %0d want 6", n_hs - h0); end
    total++; if (n_os - o0 !== 2) begin bad++; $display("FAIL ignore_rows: got %0d want 2", n_os - o0); end
    total++; if (n_done - d0 !== 1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL ignore_end: done=%0d busy=%b want 1 0", n_done - d0, bus.busy);
    end
  endtask
  task automatic test_reset_mid;
    int d0;
    push_run(2, 4);
    bus.step_ack = 1;
    start(32'h0002_0004, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1; @(posedge clk); #1;
    reset = 0; bus.step_ack = 0;
    q.delete();
    d0 = n_done;
    total++;
    if ({bus.busy, bus.inner_req, bus.outer0} !== 3'b001 || bus.ocount !== 16'd0 || bus.icount !== 16'd0) begin
      bad++; $display("FAIL midreset: busy=%b req=%b outer0=%b ocount=%0d icount=%0d want 0 0 1 0 0",
                      bus.busy, bus.inner_req, bus.outer0, bus.ocount, bus.icount);
    end
    repeat (10) @(posedge clk); #1;
    total++; if (n_done !== d0) begin bad++; $display("FAIL midreset_done: got %0d pulses want 0", n_done - d0); end
  endtask
`ifdef BLIT_LOOP_STOP_EN
  task automatic test_stop;
    int h0 = n_hs, lat;
    push_run(1, 8);
    bus.step_ack = 1;
    start(32'h0001_0008, 0);
    repeat (3) @(posedge clk); #1;
    total++; if (bus.icount !== 16'd5) begin bad++; $display("FAIL stop_pre: icount=%0d want 5", bus.icount); end
    bus.stop = 1; @(posedge clk); #1; bus.stop = 0;
    total++;
    if (bus.icount !== 16'd5 || bus.inner_req !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL stop_enter: icount=%0d req=%b busy=%b want 5 0 1", bus.icount, bus.inner_req, bus.busy);
    end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.icount !== 16'd5) begin bad++; $display("FAIL stop_hold: icount=%0d want 5", bus.icount); end
    bus.resume = 1; @(posedge clk); #1; bus.resume = 0;
    wait_done(50, lat);
    bus.step_ack = 0;
    total++; if (n_hs - h0 !== 8) begin bad++; $display("FAIL stop_steps: got %0d want 8", n_hs - h0); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_basic;
    test_ack_toggle;
    test_zero_rows;
    test_zero_width;
    test_busy_ignore;
    test_reset_mid;
`ifdef BLIT_LOOP_STOP_EN
    test_stop;
`endif
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL leftover: %0d expected events never seen", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
